data_ram: RTL and testbench

DATA_RAM -- requirements
Module: data_ram

---
 rtl/data_ram.sv | 135 +++++++++++++
 tb/tb_data_ram.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// Single-port byte-enabled data RAM with a registered, back-pressured read response.
// Optional macro RAM_INIT_CLEAR_EN zeroes every word after reset, one word per cycle.
module data_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wren,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFW  = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IW    = ADDR_WIDTH - OFFW;
    localparam int CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [IW:0]   DEPTH_V  = (IW + 1)'(DEPTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

`ifdef RAM_INIT_CLEAR_EN
    localparam state_t RST_STATE = CLEAR;
`else
    localparam state_t RST_STATE = READY;
`endif

    state_t                state_q, state_d;
    logic [CW-1:0]         clr_cnt_q, clr_cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IW-1:0] word_idx;
    logic [CW-1:0] mem_idx;
    logic          in_range;
    logic          accept;
    logic          rd_accept;
    logic          wr_accept;

    // Byte-offset bits are dropped; anything at or beyond DEPTH is out of range.
    assign word_idx = req_addr[ADDR_WIDTH-1:OFFW];
    assign mem_idx  = word_idx[CW-1:0];
    assign in_range = ({1'b0, word_idx} < DEPTH_V);

    assign req_ready = (state_q == READY) && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_wren;
    assign wr_accept = accept && req_wren;

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

`ifdef RAM_INIT_CLEAR_EN
    assign busy = (state_q == CLEAR);
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = READY;
                end
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    // A new read overwrites the held response in the same cycle it is consumed.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        if (rd_accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = !in_range;
            rsp_data_d  = in_range ? mem[mem_idx] : '0;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_STATE;
            clr_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_accept && in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (req_be[b]) begin
                    mem[mem_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// Scoreboard bench for data_ram: a byte-array reference model predicts every read,
// a monitor pops and compares responses as they are consumed.
module tb_data_ram;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 13;
    localparam int BW    = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_wren;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_be;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;

    data_ram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wren  (req_wren),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    int           tests = 0;
    int           fails = 0;
    int           cyc   = 0;
    exp_t         expq[$];
    byte unsigned mb[DEPTH*BW];
    bit           rd_acc_at[int];
    bit           rr_random = 1'b0;
    bit           rr_fixed  = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model_read(input int addr);
        exp_t e;
        int   idx;
        idx = addr / BW;
        e.data = '0;
        e.err  = 1'b1;
        if (idx < DEPTH) begin
            e.err = 1'b0;
            for (int b = 0; b < BW; b++) e.data[8*b +: 8] = mb[idx*BW + b];
        end
        return e;
    endfunction

    task automatic model_write(input int addr, input logic [DW-1:0] d, input logic [BW-1:0] be);
        int idx;
        idx = addr / BW;
        if (idx < DEPTH) begin
            for (int b = 0; b < BW; b++) if (be[b]) mb[idx*BW + b] = d[8*b +: 8];
        end
    endtask

    // Consumer-side ready: either held fixed or randomly throttled.
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = rr_random ? ($urandom_range(0, 3) != 0) : rr_fixed;
        end
    end

    // Issue one request and hold it until accepted; the model is updated at acceptance.
    task automatic do_req(input bit wren, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [BW-1:0] be, output int acc_cyc);
        bit done;
        done      = 1'b0;
        acc_cyc   = -1;
        req_valid = 1'b1;
        req_wren  = wren;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (req_ready) begin
                done    = 1'b1;
                acc_cyc = cyc;
                if (wren) begin
                    model_write(int'(addr), wdata, be);
                end else begin
                    expq.push_back(model_read(int'(addr)));
                    rd_acc_at[cyc] = 1'b1;
                end
            end
            @(posedge clk);
        end
        #1;
        req_valid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL req_accept_timeout: addr %0h not accepted within 200 cycles", addr);
        end
    endtask

    // Monitor: read latency and in-order data/err of every consumed response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rd_acc_at.exists(cyc - 1)) check("rsp_latency", rsp_valid, 1);
                if (rsp_valid && rsp_ready) begin
                    if (expq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rsp_unexpected: got data %0h with no read outstanding", rsp_data);
                    end else begin
                        e = expq.pop_front();
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_err", rsp_err, e.err);
                    end
                end
            end
        end
    end

    initial begin
        int        ac;
        int        sac[8];
        int        n;
        int        idx;
        logic [DW-1:0] held;
        logic [AW-1:0] a;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wren  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        for (int i = 0; i < DEPTH*BW; i++) mb[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_err", rsp_err, 0);

`ifdef RAM_INIT_CLEAR_EN
        n = 0;
        while (busy && n < DEPTH + 10) begin
            if (req_ready) check("ready_while_busy", req_ready, 0);
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, DEPTH);
        check("ready_after_clear", req_ready, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            a = AW'($urandom_range(0, DEPTH*BW - 1));
            do_req(1'b0, a, '0, '0, ac);
        end
`else
        check("busy_tied_low", busy, 0);
        check("ready_after_reset", req_ready, 1);
        @(posedge clk);
        #1;
`endif

        // Populate words 0..31 so every later read has defined contents.
        for (int i = 0; i < 32; i++) do_req(1'b1, AW'(i*BW), $urandom, '1, ac);

        do_req(1'b1, 13'h010, 32'hDEADBEEF, 4'hF, ac);
        do_req(1'b0, 13'h010, '0, '0, ac);
        do_req(1'b1, 13'h013, 32'h00001122, 4'b0011, ac);
        do_req(1'b0, 13'h010, '0, '0, ac);

        do_req(1'b1, 13'h1000, 32'hCAFEF00D, 4'hF, ac);
        do_req(1'b0, 13'h1000, '0, '0, ac);
        do_req(1'b0, 13'h0000, '0, '0, ac);
        do_req(1'b0, 13'h1FFE, '0, '0, ac);

        // Back-to-back write then read of the same word.
        do_req(1'b1, 13'h024, 32'h13579BDF, 4'b1010, ac);
        do_req(1'b0, 13'h025, '0, '0, ac);

        for (int i = 0; i < 8; i++) do_req(1'b0, AW'(i*BW + $urandom_range(0, BW-1)), '0, '0, sac[i]);
        for (int i = 1; i < 8; i++) check("stream_gap", sac[i] - sac[i-1], 1);

        // Stall: hold the response with rsp_ready low for 5 cycles.
        repeat (3) @(posedge clk);
        rr_fixed = 1'b0;
        @(posedge clk);
        #2;
        do_req(1'b0, 13'h010, '0, '0, ac);
        @(negedge clk);
        held = rsp_data;
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", rsp_valid, 1);
            check("stall_data", rsp_data, held);
            check("stall_req_ready", req_ready, 0);
            if (k < 4) @(negedge clk);
        end
        rr_fixed = 1'b1;
        @(negedge clk);
        check("unstall_req_ready", req_ready, 1);
        @(posedge clk);
        #1;

        rr_random = 1'b1;
        for (int i = 0; i < 300; i++) begin
            idx = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, (1 << AW) / BW - 1)
                                               : $urandom_range(0, 31);
            a = AW'(idx*BW + $urandom_range(0, BW-1));
            do_req($urandom_range(0, 1) == 1, a, $urandom, BW'($urandom_range(0, (1 << BW) - 1)), ac);
        end
        rr_random = 1'b0;
        rr_fixed  = 1'b1;
        n = 0;
        while (expq.size() != 0 && n < 100) begin
            n++;
            @(posedge clk);
        end
        @(negedge clk);
        check("queue_drained", expq.size(), 0);

        // Reset while a response is held must discard it.
        rr_fixed = 1'b0;
        @(posedge clk);
        #2;
        do_req(1'b0, 13'h010, '0, '0, ac);
        @(negedge clk);
        check("held_before_rst", rsp_valid, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expq.delete();
        rd_acc_at.delete();
        @(negedge clk);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_data", rsp_data, 0);
        check("mid_rst_rsp_err", rsp_err, 0);
        rr_fixed = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
